// File: rtl/digital_lock_ctrl.sv
// digital_lock_ctrl
//   Parametrised code lock. A PW_WIDTH-bit code is compared against the
//   stored password on each cycle that try is high. Consecutive failures are
//   counted. Reaching MAX_FAILS failures starts a timed lockout that lasts
//   LOCKOUT_CYCLES clocks.
//
//   Optional feature macro: PW_PROG_EN
//     defined   : while unlocked, prog=1 loads code as the new password.
//     undefined : the password is the constant DEFAULT_PW, prog is ignored,
//                 and no password register exists.
//
//   Every output is a flop, so there is no combinational path from any input
//   to any output.
module digital_lock_ctrl #(
  parameter int                     PW_WIDTH       = 4,
  parameter logic [PW_WIDTH-1:0]    DEFAULT_PW     = PW_WIDTH'(4'b0101),
  parameter int                     MAX_FAILS      = 3,
  parameter int                     LOCKOUT_CYCLES = 10,
  localparam int                    FW             = $clog2(MAX_FAILS + 1),
  localparam int                    TW             = $clog2(LOCKOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PW_WIDTH-1:0] code,
  input  logic                try,
  input  logic                close,
  input  logic                prog,
  output logic                unlocked,
  output logic                lockout,
  output logic                fail,
  output logic [FW-1:0]       fail_cnt,
  output logic [TW-1:0]       lock_timer
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [FW-1:0] CNT_ONE    = FW'(1);

  state_t              state_q,      state_d;
  logic                unlocked_q,   unlocked_d;
  logic                lockout_q,    lockout_d;
  logic                fail_q,       fail_d;
  logic [FW-1:0]       fail_cnt_q,   fail_cnt_d;
  logic [TW-1:0]       lock_timer_q, lock_timer_d;

  // Password currently in force: a register when programmable, else a constant.
  logic [PW_WIDTH-1:0] pw_cur;

`ifdef PW_PROG_EN
  logic [PW_WIDTH-1:0] pw_q, pw_d;
  assign pw_cur = pw_q;
`else
  assign pw_cur = DEFAULT_PW;
  // Without programming support, prog is part of the port list but unused.
  logic unused_prog;
  assign unused_prog = prog;
`endif

  logic code_match;
  logic last_fail;

  assign code_match = (code == pw_cur);
  // True when one more rejected attempt reaches the lockout threshold.
  assign last_fail  = ((int'(fail_cnt_q) + 1) >= MAX_FAILS);

  // Next-state, counter, timer and password update for one clock.
  always_comb begin
    state_d      = state_q;
    fail_cnt_d   = fail_cnt_q;
    lock_timer_d = lock_timer_q;
    fail_d       = 1'b0;
`ifdef PW_PROG_EN
    pw_d         = pw_q;
`endif

    case (state_q)
      ST_LOCKED: begin
        if (try) begin
          if (code_match) begin
            state_d    = ST_UNLOCKED;
            fail_cnt_d = '0;
          end else if (last_fail) begin
            // The counter restarts from zero after the lockout expires.
            state_d      = ST_LOCKOUT;
            fail_d       = 1'b1;
            fail_cnt_d   = '0;
            lock_timer_d = TIMER_LOAD;
          end else begin
            fail_d     = 1'b1;
            fail_cnt_d = fail_cnt_q + CNT_ONE;
          end
        end
      end

      ST_UNLOCKED: begin
        // try is deliberately ignored here: no compare and no fail pulse.
`ifdef PW_PROG_EN
        if (prog) begin
          pw_d = code;
        end
`endif
        if (close) begin
          state_d = ST_LOCKED;
        end
      end

      ST_LOCKOUT: begin
        // try and close are ignored. A timer value of 1 marks the final
        // lockout cycle. The <= guard also ensures the timer cannot wrap.
        if (lock_timer_q <= TIMER_ONE) begin
          state_d      = ST_LOCKED;
          lock_timer_d = '0;
        end else begin
          lock_timer_d = lock_timer_q - TIMER_ONE;
        end
      end

      default: begin
        // This is an unreachable encoding. Recover to a clean locked state.
        state_d      = ST_LOCKED;
        fail_cnt_d   = '0;
        lock_timer_d = '0;
      end
    endcase

    // The status outputs are registered copies of the state being entered.
    unlocked_d = (state_d == ST_UNLOCKED);
    lockout_d  = (state_d == ST_LOCKOUT);
  end

  // State and output registers. Reset clears everything at once, including
  // an active lockout and any programmed password.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_LOCKED;
      unlocked_q   <= 1'b0;
      lockout_q    <= 1'b0;
      fail_q       <= 1'b0;
      fail_cnt_q   <= '0;
      lock_timer_q <= '0;
`ifdef PW_PROG_EN
      pw_q         <= DEFAULT_PW;
`endif
    end else begin
      state_q      <= state_d;
      unlocked_q   <= unlocked_d;
      lockout_q    <= lockout_d;
      fail_q       <= fail_d;
      fail_cnt_q   <= fail_cnt_d;
      lock_timer_q <= lock_timer_d;
`ifdef PW_PROG_EN
      pw_q         <= pw_d;
`endif
    end
  end

  assign unlocked   = unlocked_q;
  assign lockout    = lockout_q;
  assign fail       = fail_q;
  assign fail_cnt   = fail_cnt_q;
  assign lock_timer = lock_timer_q;

endmodule
